led_pattern_driver: RTL and testbench
=====================================

# led_pattern_driver

Parametrised counter-to-LED driver for board bring-up and status display. It contains a programmable prescaler, an up/down counter with load and wrap reporting, and a bounce-scanner state machine. Four selectable display modes drive a configurable number of LEDs. It sits between a board top level and its LED pins, and is the general-purpose successor to the fixed 4-LED binary counter display.

## Interface
- `LED_COUNT`, default 4: number of LED outputs; 1 ≤ `LED_COUNT` ≤ `COUNTER_WIDTH`.
- `COUNTER_WIDTH`, default 8: width of the main counter.
- `PRESCALE_WIDTH`, default 24: width of the prescaler and of the `Prescale` input.

- `Clock`  in  1: single clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Enable`  in  1: 1 = prescaler runs; 0 = prescaler and all state hold.
- `Prescale`  in  `PRESCALE_WIDTH`: tick period minus one, in `Clock` cycles.
- `Direction`  in  1: 0 = count up, 1 = count down.
- `Mode`  in  2: display mode; 0 binary, 1 gray, 2 bounce, 3 blink.
- `Load`  in  1: synchronous load strobe.
- `LoadValue`  in  `COUNTER_WIDTH`: value written into `Counter` on `Load`.
- `Counter`  out  `COUNTER_WIDTH`: registered counter value.
- `LEDs`  out  `LED_COUNT`: LED drive, active-high.
- `Tick`  out  1: registered one-cycle pulse, the cycle after each prescaler expiry.
- `Wrap`  out  1: registered one-cycle pulse when `Counter` wraps.

## Operation
**Prescaler**
- Internal count `pcnt` is `PRESCALE_WIDTH` bits wide.
- When `Enable`=1: if `pcnt` ≥ `Prescale`, then `pcnt`←0 and an internal tick is raised; otherwise `pcnt`←`pcnt`+1.
- Using ≥ rather than = means a mid-count decrease of `Prescale` expires on the next enabled cycle instead of waiting for `pcnt` to wrap.
- `Prescale`=0 gives a tick on every enabled cycle.
- When `Enable`=0: `pcnt`, `Counter` and the bounce state all hold, and no tick is raised.

**Counter**
- On tick: `Counter`←`Counter`+1 if `Direction`=0, else `Counter`−1, modulo 2^`COUNTER_WIDTH`.
- `Wrap` is set on a tick that takes `Counter` from all-ones to 0 (up) or from 0 to all-ones (down).

**Bounce scanner**
- State: position `pos` (0..`LED_COUNT`−1) and direction `dir` (RIGHT or LEFT). Reset state: `pos`=0, `dir`=RIGHT.
- Advances on every tick, regardless of `Mode`.
- RIGHT: if `pos`=`LED_COUNT`−1 then `dir`←LEFT and `pos`←`pos`−1; else `pos`←`pos`+1.
- LEFT: if `pos`=0 then `dir`←RIGHT and `pos`←1; else `pos`←`pos`−1.
- `LED_COUNT`=1: `pos` stays 0 permanently.

**Load**
- Highest priority; acts regardless of `Enable`.
- `Counter`←`LoadValue`, `pcnt`←0, `pos`←0, `dir`←RIGHT.
- No tick and no `Wrap` in a load cycle, even if the prescaler would have expired.

**LED decode** (combinational from registered state and `Mode`)
- Mode 0: `LEDs` = `Counter[LED_COUNT-1:0]`.
- Mode 1: `LEDs` = (`Counter` ^ (`Counter`>>1))[LED_COUNT-1:0].
- Mode 2: `LEDs` = one-hot at `pos`.
- Mode 3: all `LEDs` = `Counter[0]`.

## Timing
**Reset values**
- `Counter`=0, `pcnt`=0, `pos`=0, `dir`=RIGHT, `Tick`=0, `Wrap`=0.
- `LEDs` at reset: 0 in modes 0, 1 and 3; `LEDs[0]`=1 (all others 0) in mode 2.
- Reset asserted mid-count clears all state immediately, without waiting for a clock edge.

**Latency**
- With `Enable` held at 1, a tick occurs every `Prescale`+1 cycles.
- `Counter` updates on the edge where the prescaler expires.
- `Tick` and `Wrap` are high for exactly the one cycle after that edge, aligned with the new `Counter` value.

**Mode and input changes**
- `LEDs` follows a `Mode` change in the same cycle, with no state disturbance.
- A `Direction` change takes effect at the next tick.

**Simultaneous events**
- `Load` together with a tick: load wins.
- `Load` with `Enable`=0: load is still performed.

## Test plan
- **Reset and enable:** reset, `Prescale`=3, `Enable`=1, `Mode`=0 → `Tick` high every 4th cycle; `Counter` reads 1, 2, 3…; `LEDs` equals `Counter[3:0]`.
- **Wrap, both directions:** `Prescale`=0, `Load` `LoadValue`=8'hFE, then run up → `Counter` FF, 00, with `Wrap` high only with 00. Then `Direction`=1 from 01 → 00, FF, with `Wrap` high only with FF.
- **Bounce:** `Mode`=2, `LED_COUNT`=4, `Prescale`=0 → `LEDs` sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- **Gray:** `Mode`=1, load 8'h05 → `LEDs`=4'b0111; next tick (06) → 4'b0101.
- **Prescaler decrease and Load priority:** `Prescale`=100; at `pcnt`=50 set `Prescale`=10 → tick on the next cycle. `Load` asserted in the cycle the prescaler expires → `Counter`=`LoadValue`, no `Tick`, `pos`=0.
- **Enable and async reset:** `Enable`=0 for 20 cycles → `Counter`, `pcnt` and `LEDs` frozen. Then assert `Reset` between clock edges → all outputs go to reset values before the next edge.

Source files
------------

// File: rtl/led_pattern_driver.sv
// Counter-to-LED driver: programmable prescaler, loadable up/down counter with wrap
// pulse, bounce scanner, and a four-mode LED decoder.
module led_pattern_driver #(
  parameter int LED_COUNT      = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Direction,
  input  logic [1:0]                Mode,
  input  logic                      Load,
  input  logic [COUNTER_WIDTH-1:0]  LoadValue,
  output logic [COUNTER_WIDTH-1:0]  Counter,
  output logic [LED_COUNT-1:0]      LEDs,
  output logic                      Tick,
  output logic                      Wrap
);

  localparam int POS_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_t;

  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [POS_W-1:0]          r_pos;
  dir_t                      r_dir;

  logic                      w_expire;
  logic [COUNTER_WIDTH-1:0]  w_gray;
  logic [LED_COUNT-1:0]      w_onehot;

  // >= so that lowering Prescale mid-count expires at once instead of wrapping pcnt
  assign w_expire = (r_pcnt >= Prescale);
  assign w_gray   = Counter ^ (Counter >> 1);

  generate
    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_pos == POS_W'(gi));
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pcnt  <= '0;
      r_pos   <= '0;
      r_dir   <= RIGHT;
      Counter <= '0;
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
    end else begin
      Tick <= 1'b0;
      Wrap <= 1'b0;
      if (Load) begin
        Counter <= LoadValue;
        r_pcnt  <= '0;
        r_pos   <= '0;
        r_dir   <= RIGHT;
      end else if (Enable) begin
        if (w_expire) begin
          r_pcnt <= '0;
          Tick   <= 1'b1;
          if (Direction) begin
            Counter <= Counter - COUNTER_WIDTH'(1);
            Wrap    <= (Counter == '0);
          end else begin
            Counter <= Counter + COUNTER_WIDTH'(1);
            Wrap    <= (Counter == '1);
          end
          // Bounce scanner: reverse at either end, a single LED never moves
          if (LED_COUNT == 1) begin
            r_pos <= '0;
          end else begin
            case (r_dir)
              RIGHT: begin
                if (r_pos == POS_W'(LED_COUNT - 1)) begin
                  r_dir <= LEFT;
                  r_pos <= r_pos - POS_W'(1);
                end else begin
                  r_pos <= r_pos + POS_W'(1);
                end
              end
              LEFT: begin
                if (r_pos == '0) begin
                  r_dir <= RIGHT;
                  r_pos <= POS_W'(1);
                end else begin
                  r_pos <= r_pos - POS_W'(1);
                end
              end
              default: r_dir <= RIGHT;
            endcase
          end
        end else begin
          r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    LEDs = '0;
    case (Mode)
      2'd0:    LEDs = Counter[LED_COUNT-1:0];
      2'd1:    LEDs = w_gray[LED_COUNT-1:0];
      2'd2:    LEDs = w_onehot;
      default: LEDs = {LED_COUNT{Counter[0]}};
    endcase
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver: a vector table at Prescale=0 plus
// hand-written sequences for prescaler timing, load priority, enable hold and async reset.
module tb_led_pattern_driver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [23:0] Prescale;
  logic        Direction;
  logic [1:0]  Mode;
  logic        Load;
  logic [7:0]  LoadValue;
  logic [7:0]  Counter;
  logic [3:0]  LEDs;
  logic        Tick;
  logic        Wrap;

  int checks = 0;
  int errors = 0;

  led_pattern_driver #(
    .LED_COUNT(4), .COUNTER_WIDTH(8), .PRESCALE_WIDTH(24)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Prescale(Prescale),
    .Direction(Direction), .Mode(Mode), .Load(Load), .LoadValue(LoadValue),
    .Counter(Counter), .LEDs(LEDs), .Tick(Tick), .Wrap(Wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0] mode;
    logic       dir;
    logic       en;
    logic       load;
    logic [7:0] lval;
    logic [7:0] exp_cnt;
    logic [3:0] exp_leds;
    logic       exp_tick;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // mode, dir, en, load, lval, cnt, leds, tick, wrap
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 1'b1, 8'hFE, 8'hFE, 4'b1110, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 4'b1111, 1'b1, 1'b0};
    vecs[2]  = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1};
    vecs[3]  = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 4'b0001, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 4'b1111, 1'b1, 1'b1};
    vecs[6]  = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFE, 4'b1110, 1'b1, 1'b0};
    vecs[7]  = '{2'd1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05, 4'b0111, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h06, 4'b0101, 1'b1, 1'b0};
    vecs[9]  = '{2'd3, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 4'b1111, 1'b1, 1'b0};
    vecs[10] = '{2'd3, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b0};
    vecs[12] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 4'b0010, 1'b1, 1'b0};
    vecs[13] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 4'b0100, 1'b1, 1'b0};
    vecs[14] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 4'b1000, 1'b1, 1'b0};
    vecs[15] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 4'b0100, 1'b1, 1'b0};
    vecs[16] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 4'b0010, 1'b1, 1'b0};
    vecs[17] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h06, 4'b0001, 1'b1, 1'b0};
    vecs[18] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 4'b0010, 1'b1, 1'b0};
    vecs[19] = '{2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 4'b0010, 1'b0, 1'b0};
    vecs[20] = '{2'd2, 1'b0, 1'b0, 1'b1, 8'h30, 8'h30, 4'b0001, 1'b0, 1'b0};
    vecs[21] = '{2'd0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'hAA, 4'b1010, 1'b0, 1'b0};
    vecs[22] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA9, 4'b1001, 1'b1, 1'b0};

    Reset = 1'b1; Enable = 1'b0; Prescale = 24'd3; Direction = 1'b0;
    Mode = 2'd0; Load = 1'b0; LoadValue = 8'h00;
    #12;
    check("reset_counter", 32'(Counter), 32'h00);
    check("reset_tick", 32'(Tick), 32'h0);
    check("reset_wrap", 32'(Wrap), 32'h0);
    check("reset_leds_m0", 32'(LEDs), 32'h0);
    Mode = 2'd2; #1;
    check("reset_leds_m2", 32'(LEDs), 32'b0001);
    Mode = 2'd0;

    // Prescale=3: tick after every 4th edge
    @(posedge Clock); #1;
    Reset = 1'b0; Enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ps3_tick", 32'(Tick), ((k % 4) == 0) ? 32'h1 : 32'h0);
      check("ps3_counter", 32'(Counter), 32'(k / 4));
      check("ps3_leds", 32'(LEDs), 32'(k / 4) & 32'hF);
      $display("ps3 cycle %0d: counter=%0h tick=%0b leds=%b", k, Counter, Tick, LEDs);
    end

    Prescale = 24'd0;
    for (int i = 0; i < 23; i++) begin
      Mode = vecs[i].mode; Direction = vecs[i].dir; Enable = vecs[i].en;
      Load = vecs[i].load; LoadValue = vecs[i].lval;
      step();
      check("vec_counter", 32'(Counter), 32'(vecs[i].exp_cnt));
      check("vec_leds", 32'(LEDs), 32'(vecs[i].exp_leds));
      check("vec_tick", 32'(Tick), 32'(vecs[i].exp_tick));
      check("vec_wrap", 32'(Wrap), 32'(vecs[i].exp_wrap));
      $display("vec %0d: mode=%0d load=%0b counter=%0h leds=%b tick=%0b wrap=%0b",
               i, Mode, Load, Counter, LEDs, Tick, Wrap);
    end

    // Prescaler decrease mid-count
    Direction = 1'b0; Enable = 1'b1; Mode = 2'd2; Prescale = 24'd100;
    Load = 1'b1; LoadValue = 8'h10;
    step();
    Load = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      check("ps100_no_tick", 32'(Tick), 32'h0);
    end
    Prescale = 24'd10;
    step();
    check("ps_decrease_tick", 32'(Tick), 32'h1);
    check("ps_decrease_counter", 32'(Counter), 32'h11);
    $display("prescale decrease: counter=%0h tick=%0b", Counter, Tick);

    // Load in the cycle the prescaler would expire
    for (int k = 0; k < 10; k++) step();
    Load = 1'b1; LoadValue = 8'h5A;
    step();
    Load = 1'b0;
    check("load_prio_counter", 32'(Counter), 32'h5A);
    check("load_prio_tick", 32'(Tick), 32'h0);
    check("load_prio_leds", 32'(LEDs), 32'b0001);
    $display("load priority: counter=%0h tick=%0b leds=%b", Counter, Tick, LEDs);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("after_load_tick", 32'(Tick), (k == 11) ? 32'h1 : 32'h0);
    end
    check("after_load_counter", 32'(Counter), 32'h5B);

    // Enable hold: pcnt=2, freeze 20 cycles, then 9 more enabled edges to expire
    step(); step();
    Enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_counter", 32'(Counter), 32'h5B);
      check("hold_leds", 32'(LEDs), 32'b0010);
      check("hold_tick", 32'(Tick), 32'h0);
    end
    $display("enable hold: counter=%0h leds=%b", Counter, LEDs);
    Enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("resume_tick", 32'(Tick), (k == 9) ? 32'h1 : 32'h0);
    end
    check("resume_counter", 32'(Counter), 32'h5C);
    check("resume_leds", 32'(LEDs), 32'b0100);

    // Asynchronous reset between edges while Tick is high
    #2 Reset = 1'b1;
    #1;
    check("async_counter", 32'(Counter), 32'h00);
    check("async_tick", 32'(Tick), 32'h0);
    check("async_wrap", 32'(Wrap), 32'h0);
    check("async_leds_m2", 32'(LEDs), 32'b0001);
    $display("async reset: counter=%0h tick=%0b leds=%b", Counter, Tick, LEDs);
    step();
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
